// File: rtl/write_register_pkg.sv
// rtl/write_register_pkg.sv - shared types, address map and byte-merge helper for write_register
package write_register_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DATA    = 2'd2;
  localparam logic [1:0] ADDR_SCRATCH = 2'd3;

  localparam int BUS_W = 32;

  // Reference byte merge at the default bus width: enabled bytes come from new_value
  function automatic logic [BUS_W-1:0] byte_merge(
    input logic [BUS_W-1:0]   old_value,
    input logic [BUS_W-1:0]   new_value,
    input logic [BUS_W/8-1:0] be
  );
    logic [BUS_W-1:0] result;
    result = old_value;
    for (int i = 0; i < BUS_W / 8; i++) begin
      if (be[i]) result[8*i +: 8] = new_value[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/write_register_be_merge.sv
// rtl/write_register_be_merge.sv - combinational byte-enable merge with expanded bit mask
module be_merge
  import write_register_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_value,
  input  logic [DATA_W-1:0]   new_value,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged,
  output logic [DATA_W-1:0]   mask
);

  // Expand each byte enable into eight mask bits
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
  end

  assign merged = (old_value & ~mask) | (new_value & mask);

endmodule

// File: rtl/write_register.sv
// rtl/write_register.sv - bus write side of the button-controller register file
module write_register
  import write_register_pkg::*;
#(
  parameter int                DATA_W          = 32,
  parameter logic [DATA_W-1:0] CTRL_RESET      = '0,
  parameter logic [DATA_W-1:0] SELF_CLEAR_MASK = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter logic [DATA_W-1:0] SCRATCH_RESET   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [1:0]          wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   hw_event,
  output logic [DATA_W-1:0]   register_0,
  output logic [DATA_W-1:0]   register_1,
  output logic [DATA_W-1:0]   register_2,
  output logic [DATA_W-1:0]   register_3,
  output logic                data_strobe,
  output logic                done,
  output logic                busy
);

  state_t              state;
  logic [1:0]          hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic [DATA_W/8-1:0] hold_be;

  logic                apply;
  logic [DATA_W-1:0]   old_value;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   be_mask;
  logic [DATA_W-1:0]   status_next;

  assign apply = (state == APPLY);

  // Select the register that the held address will merge into
  always_comb begin
    old_value = register_3;
    case (hold_addr)
      ADDR_CTRL: old_value = register_0;
      ADDR_DATA: old_value = register_2;
      default:   old_value = register_3;
    endcase
  end

  be_merge #(
    .DATA_W (DATA_W)
  ) u_be_merge (
    .old_value (old_value),
    .new_value (hold_data),
    .be        (hold_be),
    .merged    (merged),
    .mask      (be_mask)
  );

  // Written ones clear enabled bits; hardware events are OR-ed in afterwards so set wins
  assign status_next = ((apply && (hold_addr == ADDR_STATUS))
                        ? (register_1 & ~(hold_data & be_mask))
                        : register_1) | hw_event;

  // Handshake FSM: capture in IDLE, update in APPLY, acknowledge in ACK until wr drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_be     <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      data_strobe <= 1'b0;
    end else begin
      data_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (wr) begin
            hold_addr <= wr_addr;
            hold_data <= wr_data;
            hold_be   <= wr_be;
            busy      <= 1'b1;
            state     <= APPLY;
          end
        end
        APPLY: begin
          done        <= 1'b1;
          data_strobe <= (hold_addr == ADDR_DATA) && (|hold_be);
          state       <= ACK;
        end
        ACK: begin
          if (!wr) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Register file: one-shot control bits decay every cycle unless being written this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      register_0 <= CTRL_RESET;
      register_1 <= '0;
      register_2 <= '0;
      register_3 <= SCRATCH_RESET;
    end else begin
      register_0 <= register_0 & ~SELF_CLEAR_MASK;
      register_1 <= status_next;
      if (apply) begin
        case (hold_addr)
          ADDR_CTRL:    register_0 <= merged;
          ADDR_DATA:    register_2 <= merged;
          ADDR_SCRATCH: register_3 <= merged;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_register.sv
// tb/tb_write_register.sv - randomized and directed self-checking bench for write_register
module tb_write_register;

  localparam logic [31:0] SC_MASK = 32'h0000_0001;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] hw_event;
  logic [31:0] register_0;
  logic [31:0] register_1;
  logic [31:0] register_2;
  logic [31:0] register_3;
  logic        data_strobe;
  logic        done;
  logic        busy;

  int n_cmp;
  int n_err;

  logic [31:0] m_reg [4];

  write_register dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .hw_event    (hw_event),
    .register_0  (register_0),
    .register_1  (register_1),
    .register_2  (register_2),
    .register_3  (register_3),
    .data_strobe (data_strobe),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_reg0"}, register_0, m_reg[0]);
    check({tag, "_reg1"}, register_1, m_reg[1]);
    check({tag, "_reg2"}, register_2, m_reg[2]);
    check({tag, "_reg3"}, register_3, m_reg[3]);
  endtask

  task automatic model_reset();
    m_reg[0] = 32'h0;
    m_reg[1] = 32'h0;
    m_reg[2] = 32'h0;
    m_reg[3] = 32'h0;
  endtask

  // Byte-wise choice between old and new value, written as plain byte arithmetic
  function automatic logic [31:0] pick_bytes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      r = r | ((be[b] ? ((new_v >> (8*b)) & 32'hFF) : ((old_v >> (8*b)) & 32'hFF)) << (8*b));
    end
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_event(input logic [31:0] ev);
    hw_event = ev;
    cycle();
    hw_event = 32'h0;
    m_reg[1] = m_reg[1] | ev;
    m_reg[0] = m_reg[0] & ~SC_MASK;
    check("event_reg1", register_1, m_reg[1]);
  endtask

  // Full handshake; ev is pulsed during the APPLY cycle, extra = additional ACK cycles with wr held
  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int extra, input logic [31:0] ev);
    logic [31:0] clr;
    wr = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cycle();
    m_reg[0] = m_reg[0] & ~SC_MASK;
    check("apply_done", {31'h0, done}, 32'h0);
    check("apply_busy", {31'h0, busy}, 32'h1);
    check("apply_strobe", {31'h0, data_strobe}, 32'h0);
    wr_addr = 2'($urandom); wr_data = $urandom; wr_be = 4'($urandom);
    hw_event = ev;
    cycle();
    hw_event = 32'h0;
    if (a == 2'd1) begin
      clr = pick_bytes(32'h0, d, be);
      m_reg[1] = (m_reg[1] & ~clr) | ev;
    end else begin
      m_reg[1] = m_reg[1] | ev;
      m_reg[a] = pick_bytes(m_reg[a], d, be);
    end
    check("ack_done", {31'h0, done}, 32'h1);
    check("ack_busy", {31'h0, busy}, 32'h1);
    check("ack_strobe", {31'h0, data_strobe}, {31'h0, (a == 2'd2) && (be != 4'h0)});
    check_regs("ack");
    m_reg[0] = m_reg[0] & ~SC_MASK;
    for (int k = 0; k < extra; k++) begin
      cycle();
      check("hold_done", {31'h0, done}, 32'h1);
      check("hold_strobe", {31'h0, data_strobe}, 32'h0);
    end
    wr = 1'b0;
    cycle();
    check("end_done", {31'h0, done}, 32'h0);
    check("end_busy", {31'h0, busy}, 32'h0);
    check("end_strobe", {31'h0, data_strobe}, 32'h0);
    check_regs("end");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; wr = 1'b0; wr_addr = 2'h0; wr_data = 32'h0; wr_be = 4'h0; hw_event = 32'h0;
    model_reset();
    cycle();
    cycle();
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_strobe", {31'h0, data_strobe}, 32'h0);
    check_regs("rst");
    reset = 1'b0;
    cycle();
    check_regs("post_rst");

    do_write(2'd3, 32'hDEAD_BEEF, 4'hF, 2, 32'h0);
    check("scratch_value", register_3, 32'hDEAD_BEEF);

    do_write(2'd2, 32'hAAAA_AAAA, 4'hF, 0, 32'h0);
    do_write(2'd2, 32'h1234_5678, 4'b0011, 1, 32'h0);
    check("data_merge", register_2, 32'hAAAA_5678);

    pulse_event(32'h0000_0005);
    check("event_set", register_1, 32'h5);
    do_write(2'd1, 32'h1, 4'hF, 0, 32'h0);
    check("w1c_clear", register_1, 32'h4);
    pulse_event(32'h0000_0001);
    do_write(2'd1, 32'h1, 4'hF, 0, 32'h1);
    check("set_wins", register_1, 32'h5);

    do_write(2'd0, 32'h0000_0003, 4'hF, 1, 32'h0);
    check("self_clear", register_0, 32'h2);

    wr = 1'b1; wr_addr = 2'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    cycle();
    cycle();
    check("pre_rst_done", {31'h0, done}, 32'h1);
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_reg3", register_3, 32'h0);
    check_regs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    wr = 1'b0;
    cycle();
    do_write(2'd3, 32'h0BAD_F00D, 4'hF, 0, 32'h0);

    do_write(2'd2, $urandom, 4'h0, 1, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  ra;
      logic [31:0] ev;
      ra = 2'($urandom);
      ev = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      do_write(ra, $urandom, 4'($urandom), $urandom_range(0, 2), ev);
      if ($urandom_range(0, 3) == 0) pulse_event($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
